// File: rtl/rdyack_rr_arbiter_pkg.sv
// Shared definitions for the rdy/ack round-robin arbiter.
// Provides the select/pointer width helper and a switch for the
// simulation-only protocol checks.
package rdyack_rr_arbiter_pkg;

   // Set to 0 to strip the simulation protocol checks from the build.
   localparam bit ARB_ASSERT_EN = 1'b1;

   // Index width for N requesters. This width is never less than one bit,
   // so N=1 still gets a real select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rdyack_rr_arbiter_rr_pick.sv
// Rotate-priority picker. This block is purely combinational.
// It returns the first set request found by scanning upward from i_ptr.
// The scan wraps past N-1 back to 0.
module rdyack_rr_arbiter_rr_pick
   import rdyack_rr_arbiter_pkg::*;
#(
   parameter int N = 4,
   localparam int SW = sel_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [SW-1:0] i_ptr,
   output logic          o_valid,
   output logic [SW-1:0] o_idx
);

   logic [N-1:0] w_rot;

   // Rotate the requests so that bit 0 is the requester at the pointer.
   assign w_rot = N'({i_req, i_req} >> i_ptr);

   // Find the lowest set rotated bit, then map it back to a requester index.
   always_comb begin
      int sum;
      o_valid = 1'b0;
      o_idx   = '0;
      sum     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            sum = int'(i_ptr) + k;
            if (sum >= N) sum = sum - N;
            o_valid = 1'b1;
            o_idx   = SW'(sum);
         end
      end
   end

endmodule

// File: rtl/rdyack_rr_arbiter.sv
// N-to-1 rdy/ack round-robin arbiter with a registered output slot.
// Grants are issued combinationally on src_acks. The granted index is
// registered into o_sel together with dst_rdy.
// Optional macro ARB_CREDIT_EN adds i_credit_ret and an outstanding-grant
// counter. That counter stops granting once N_CREDIT transfers are unretired.
module rdyack_rr_arbiter
   import rdyack_rr_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int N_CREDIT = 8,
   localparam int SW = sel_width(N)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [N-1:0]  src_rdys,
   output logic [N-1:0]  src_acks,
   output logic          dst_rdy,
   input  logic          dst_ack,
`ifdef ARB_CREDIT_EN
   input  logic          i_credit_ret,
`endif
   output logic [SW-1:0] o_sel
);

   if (N < 1) begin : g_bad_n
      $error("rdyack_rr_arbiter: N must be >= 1");
   end
   if (N_CREDIT < 1) begin : g_bad_credit
      $error("rdyack_rr_arbiter: N_CREDIT must be >= 1");
   end

   logic          r_dst_rdy;
   logic [SW-1:0] r_sel;
   logic [SW-1:0] r_ptr;
   logic          w_valid;
   logic [SW-1:0] w_idx;
   logic          w_can_take;
   logic          w_grant;

   rdyack_rr_arbiter_rr_pick #(.N(N)) u_pick (
      .i_req   (src_rdys),
      .i_ptr   (r_ptr),
      .o_valid (w_valid),
      .o_idx   (w_idx)
   );

`ifdef ARB_CREDIT_EN
   localparam int CW = $clog2(N_CREDIT + 1);

   logic [CW-1:0] r_credit;
   logic          w_credit_full;

   // Blocking on credits uses the registered count. As a result, a return
   // that arrives while the counter is full only unblocks grants on the next cycle.
   assign w_credit_full = (r_credit == CW'(N_CREDIT));
   assign w_can_take    = (!r_dst_rdy || dst_ack) && !w_credit_full;

   // Outstanding-grant count. A grant and a return in the same cycle cancel out.
   // A return while the count is zero is ignored.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_credit <= '0;
      end else if (w_grant && !i_credit_ret) begin
         r_credit <= r_credit + CW'(1);
      end else if (!w_grant && i_credit_ret && (r_credit != '0)) begin
         r_credit <= r_credit - CW'(1);
      end
   end

   if (ARB_ASSERT_EN) begin : g_credit_chk
      a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst)
         !(i_credit_ret && (r_credit == '0)));
   end
`else
   assign w_can_take = !r_dst_rdy || dst_ack;
`endif

   // Acks are suppressed while reset is held, so that no upstream
   // requester sees a handshake that the slot never captured.
   assign w_grant  = i_rst && w_can_take && w_valid;
   assign src_acks = w_grant ? (N'(1) << w_idx) : '0;
   assign dst_rdy  = r_dst_rdy;
   assign o_sel    = r_sel;

   // Output slot and round-robin pointer. A new grant replaces a slot that
   // is emptying in the same cycle, so no bubble is inserted.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_dst_rdy <= 1'b0;
         r_sel     <= '0;
         r_ptr     <= '0;
      end else if (w_grant) begin
         r_dst_rdy <= 1'b1;
         r_sel     <= w_idx;
         r_ptr     <= (w_idx == SW'(N - 1)) ? '0 : w_idx + SW'(1);
      end else if (w_can_take && dst_ack) begin
         r_dst_rdy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rdyack_rr_arbiter.sv
// Self-checking bench for rdyack_rr_arbiter (N=4).
// The reference model tracks the slot, the round-robin pointer and the
// credit count. It tracks them from the arbitration rules, not from the design's registers.
module tb_rdyack_rr_arbiter;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int NC = 2;

   logic          i_clk   = 1'b0;
   logic          i_rst   = 1'b0;
   logic [N-1:0]  src_rdys = '0;
   logic [N-1:0]  src_acks;
   logic          dst_rdy;
   logic          dst_ack = 1'b0;
   logic [SW-1:0] o_sel;
`ifdef ARB_CREDIT_EN
   logic          i_credit_ret = 1'b0;
`endif

   int n_pass  = 0;
   int n_total = 0;

   bit m_slot;
   int m_sel;
   int m_ptr;
   int m_credit;

   rdyack_rr_arbiter #(.N(N), .N_CREDIT(NC)) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .src_rdys (src_rdys),
      .src_acks (src_acks),
      .dst_rdy  (dst_rdy),
      .dst_ack  (dst_ack),
`ifdef ARB_CREDIT_EN
      .i_credit_ret (i_credit_ret),
`endif
      .o_sel    (o_sel)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running want finished");
      $fatal(1, "timeout");
   end

   // First requester at or after position p, going round the ring; -1 if none.
   function automatic int model_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (((r >> ((p + k) % N)) & N'(1)) != '0) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_acks();
      int p;
      if (!i_rst) return '0;
      if (m_slot && !dst_ack) return '0;
`ifdef ARB_CREDIT_EN
      if (m_credit >= NC) return '0;
`endif
      p = model_pick(src_rdys, m_ptr);
      if (p < 0) return '0;
      return N'(1) << p;
   endfunction

   task automatic model_reset();
      m_slot = 1'b0; m_sel = 0; m_ptr = 0; m_credit = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [N-1:0] a;
      bit allowed, ret;
      int p;
      a = model_acks();
      allowed = !m_slot || dst_ack;
      ret = 1'b0;
`ifdef ARB_CREDIT_EN
      allowed = allowed && (m_credit < NC);
      ret = i_credit_ret;
`endif
      if (a != '0) begin
         p = model_pick(src_rdys, m_ptr);
         m_slot = 1'b1;
         m_sel  = p;
         m_ptr  = (p + 1) % N;
         if (!ret) m_credit++;
      end else begin
         if (allowed && dst_ack) m_slot = 1'b0;
         if (ret && m_credit > 0) m_credit--;
      end
   endtask

   task automatic commit();
      @(posedge i_clk);
      model_edge();
      @(negedge i_clk);
   endtask

   task automatic do_reset();
      @(negedge i_clk);
      i_rst = 1'b0; src_rdys = '0; dst_ack = 1'b0;
`ifdef ARB_CREDIT_EN
      i_credit_ret = 1'b0;
`endif
      model_reset();
      @(negedge i_clk);
      i_rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      i_rst = 1'b0; src_rdys = 4'b1111; dst_ack = 1'b1;
      model_reset();
      #1;
      n_total++; if (src_acks !== 4'b0000) $display("FAIL reset_acks: got %b want 0000", src_acks); else n_pass++;
      n_total++; if (dst_rdy !== 1'b0) $display("FAIL reset_dst_rdy: got %b want 0", dst_rdy); else n_pass++;
      n_total++; if (o_sel !== 2'd0) $display("FAIL reset_o_sel: got %0d want 0", o_sel); else n_pass++;
      @(negedge i_clk);
      src_rdys = '0; dst_ack = 1'b0; i_rst = 1'b1;
   endtask

   task automatic test_single_grant();
      do_reset();
      src_rdys = 4'b0100; dst_ack = 1'b1; #1;
      n_total++; if (src_acks !== 4'b0100) $display("FAIL single_acks: got %b want 0100", src_acks); else n_pass++;
      commit();
      src_rdys = 4'b1111; #1;
      n_total++; if (dst_rdy !== 1'b1 || o_sel !== 2'd2) $display("FAIL single_slot: got rdy=%b sel=%0d want rdy=1 sel=2", dst_rdy, o_sel); else n_pass++;
      // The pointer now sits at 3, so requester 3 wins over 0..2.
      n_total++; if (src_acks !== 4'b1000) $display("FAIL single_ptr: got %b want 1000", src_acks); else n_pass++;
      commit();
   endtask

   task automatic test_round_robin();
      do_reset();
      src_rdys = 4'b1111; dst_ack = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         n_total++; if (src_acks !== (N'(1) << (c % N))) $display("FAIL rr_acks[%0d]: got %b want %b", c, src_acks, N'(1) << (c % N)); else n_pass++;
         if (c > 0) begin
            n_total++; if (dst_rdy !== 1'b1 || o_sel !== SW'((c - 1) % N)) $display("FAIL rr_sel[%0d]: got rdy=%b sel=%0d want rdy=1 sel=%0d", c, dst_rdy, o_sel, (c - 1) % N); else n_pass++;
         end
         commit();
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      src_rdys = 4'b0011; dst_ack = 1'b0; #1;
      n_total++; if (src_acks !== 4'b0001) $display("FAIL bp_first: got %b want 0001", src_acks); else n_pass++;
      commit();
      for (int c = 0; c < 4; c++) begin
         #1;
         n_total++; if (src_acks !== 4'b0000 || dst_rdy !== 1'b1 || o_sel !== 2'd0) $display("FAIL bp_hold[%0d]: got acks=%b rdy=%b sel=%0d want acks=0000 rdy=1 sel=0", c, src_acks, dst_rdy, o_sel); else n_pass++;
         commit();
      end
      dst_ack = 1'b1; #1;
      n_total++; if (src_acks !== 4'b0010) $display("FAIL bp_release: got %b want 0010", src_acks); else n_pass++;
      commit();
      #1;
      n_total++; if (o_sel !== 2'd1) $display("FAIL bp_next_sel: got %0d want 1", o_sel); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      src_rdys = 4'b0100; dst_ack = 1'b1;
      commit();
      src_rdys = 4'b0101; #1;
      n_total++; if (src_acks !== 4'b0001) $display("FAIL wrap_pick: got %b want 0001", src_acks); else n_pass++;
      commit();
      #1;
      n_total++; if (src_acks !== 4'b0100) $display("FAIL wrap_next: got %b want 0100", src_acks); else n_pass++;
      commit();
      #1;
      n_total++; if (o_sel !== 2'd2) $display("FAIL wrap_sel: got %0d want 2", o_sel); else n_pass++;
   endtask

   task automatic test_random();
      logic [N-1:0] req, exp;
      int wait_g [N];
      int worst;
      do_reset();
      req = '0; worst = 0;
      for (int i = 0; i < N; i++) wait_g[i] = 0;
      for (int c = 0; c < 400; c++) begin
         req = req | (N'($urandom) & N'($urandom));
         src_rdys = req;
         dst_ack = ($urandom_range(0, 3) != 0);
`ifdef ARB_CREDIT_EN
         i_credit_ret = (m_credit > 0) && ($urandom_range(0, 1) == 1);
`endif
         #1;
         exp = model_acks();
         n_total++; if (src_acks !== exp) $display("FAIL rand_acks[%0d]: got %b want %b", c, src_acks, exp); else n_pass++;
         n_total++; if (dst_rdy !== m_slot || o_sel !== SW'(m_sel)) $display("FAIL rand_slot[%0d]: got rdy=%b sel=%0d want rdy=%b sel=%0d", c, dst_rdy, o_sel, m_slot, m_sel); else n_pass++;
         if (exp != '0) begin
            for (int i = 0; i < N; i++) begin
               if (exp[i]) wait_g[i] = 0;
               else if (req[i]) begin
                  wait_g[i]++;
                  if (wait_g[i] > worst) worst = wait_g[i];
               end
            end
         end
         req = req & ~exp;
         commit();
      end
      n_total++; if (worst > N - 1) $display("FAIL fairness: got wait %0d want <= %0d", worst, N - 1); else n_pass++;
`ifdef ARB_CREDIT_EN
      i_credit_ret = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_rdys = 4'b0100; dst_ack = 1'b0;
      commit();
      src_rdys = 4'b1010; #2;
      n_total++; if (dst_rdy !== 1'b1 || o_sel !== 2'd2) $display("FAIL mid_before: got rdy=%b sel=%0d want rdy=1 sel=2", dst_rdy, o_sel); else n_pass++;
      i_rst = 1'b0;
      model_reset();
      #1;
      n_total++; if (dst_rdy !== 1'b0 || o_sel !== 2'd0 || src_acks !== 4'b0000) $display("FAIL mid_reset: got rdy=%b sel=%0d acks=%b want rdy=0 sel=0 acks=0000", dst_rdy, o_sel, src_acks); else n_pass++;
      @(negedge i_clk);
      i_rst = 1'b1; src_rdys = 4'b1000; dst_ack = 1'b1; #1;
      n_total++; if (src_acks !== 4'b1000) $display("FAIL mid_after_acks: got %b want 1000", src_acks); else n_pass++;
      commit();
      src_rdys = '0; #1;
      n_total++; if (dst_rdy !== 1'b1 || o_sel !== 2'd3) $display("FAIL mid_after_sel: got rdy=%b sel=%0d want rdy=1 sel=3", dst_rdy, o_sel); else n_pass++;
      commit();
   endtask

`ifdef ARB_CREDIT_EN
   task automatic test_credit();
      logic [8:0] want_grant;
      want_grant = 9'b001000011; // bit c: grant expected in cycle c
      do_reset();
      src_rdys = 4'b1111; dst_ack = 1'b1;
      for (int c = 0; c < 9; c++) begin
         i_credit_ret = (c == 5);
         #1;
         n_total++; if ((src_acks != '0) !== want_grant[c]) $display("FAIL credit_grant[%0d]: got %b want %b", c, src_acks != '0, want_grant[c]); else n_pass++;
         commit();
      end
      i_credit_ret = 1'b0;
   endtask
`endif

   initial begin
      model_reset();
      test_reset();
      test_single_grant();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_random();
      test_reset_mid();
`ifdef ARB_CREDIT_EN
      test_credit();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
